// File: rtl/modhalfq_iter.sv
// Iterative multi-lane modular scaler: a*2^-k mod Q (halve) or a*2^k mod Q (double),
// one step per clock on every lane, valid/ready on both sides.
module modhalfq_iter #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329,
  parameter int LANES = 4,
  parameter int KW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_dir,
  input  logic [KW-1:0]          in_k,
  input  logic [LANES*WIDTH-1:0] in_a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_b
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH:0] Q_EXT = (WIDTH+1)'(Q);

  // One conditional subtract brings any WIDTH-bit value into [0, Q) since 2^WIDTH < 2Q.
  function automatic logic [WIDTH-1:0] reduce_once(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] a_ext;
    a_ext = {1'b0, a};
    if (a_ext >= Q_EXT) begin
      return WIDTH'(a_ext - Q_EXT);
    end else begin
      return a;
    end
  endfunction

  // Odd values get Q added first so the shift stays exact modulo Q.
  function automatic logic [WIDTH-1:0] halve_step(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    if (x[0]) begin
      s = {1'b0, x} + Q_EXT;
    end else begin
      s = {1'b0, x};
    end
    return WIDTH'(s >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] double_step(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] y;
    y = {x, 1'b0};
    if (y >= Q_EXT) begin
      return WIDTH'(y - Q_EXT);
    end else begin
      return WIDTH'(y);
    end
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [KW-1:0]    cnt_r;
  logic [KW-1:0]    cnt_nxt_s;
  logic             dir_r;
  logic             dir_nxt_s;
  logic             out_valid_r;
  logic             accept_s;
  logic             in_ready_s;
  logic [WIDTH-1:0] lane_r     [LANES];
  logic [WIDTH-1:0] lane_nxt_s [LANES];

  // Input acceptance: idle, or done with the current result being consumed.
  always_comb begin
    in_ready_s = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    accept_s   = in_valid & in_ready_s;
  end

  // Next-state, step counter and direction latch.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dir_nxt_s   = dir_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          cnt_nxt_s   = in_k;
          dir_nxt_s   = in_dir;
          state_nxt_s = (in_k == KW'(0)) ? DONE : RUN;
        end else if (state_r == DONE && out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        // cnt is never 0 here; the guard only keeps a corrupted count from wrapping
        if (cnt_r <= KW'(1)) begin
          cnt_nxt_s   = KW'(0);
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s   = cnt_r - KW'(1);
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = KW'(0);
      end
    endcase
  end

  // Lane datapath: capture reduced inputs on accept, step every cycle in RUN.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (accept_s) begin
        lane_nxt_s[i] = reduce_once(in_a[i*WIDTH +: WIDTH]);
      end else if (state_r == RUN) begin
        lane_nxt_s[i] = dir_r ? double_step(lane_r[i]) : halve_step(lane_r[i]);
      end else begin
        lane_nxt_s[i] = lane_r[i];
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= KW'(0);
      dir_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      dir_r       <= dir_nxt_s;
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Lane registers double as the output holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= WIDTH'(0);
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= lane_nxt_s[i];
      end
    end
  end

  // Output packing.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      out_b[i*WIDTH +: WIDTH] = lane_r[i];
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_modhalfq_iter.sv
// Self-checking bench for modhalfq_iter: vector table, directed corner sequences,
// random regression, all results checked through a scoreboard queue.
module tb_modhalfq_iter;

  localparam int W  = 12;
  localparam int QM = 3329;
  localparam int L  = 4;
  localparam int KW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_dir = 1'b0;
  logic [KW-1:0]  in_k = '0;
  logic [L*W-1:0] in_a = '0;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] out_b;

  logic man_ready  = 1'b1;
  logic rand_ready = 1'b0;
  logic rnd_bit    = 1'b1;
  assign out_ready = rand_ready ? rnd_bit : man_ready;

  modhalfq_iter #(.WIDTH(W), .Q(QM), .LANES(L), .KW(KW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dir(in_dir), .in_k(in_k), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_b(out_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           d;
    logic [KW-1:0]  k;
    logic [L*W-1:0] a;
    logic [L*W-1:0] e;
  } vec_t;

  vec_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   first_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  function automatic logic [L*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [L*W-1:0] r;
    r[0*W +: W] = a0[W-1:0];
    r[1*W +: W] = a1[W-1:0];
    r[2*W +: W] = a2[W-1:0];
    r[3*W +: W] = a3[W-1:0];
    return r;
  endfunction

  // Reference: multiply by 2 or by 2^-1 = (Q+1)/2, k times, modulo Q.
  function automatic logic [W-1:0] ref_lane(input int a, input logic d, input int k);
    longint r;
    r = longint'(a) % QM;
    for (int i = 0; i < k; i++) r = d ? (r * 2) % QM : (r * ((QM + 1) / 2)) % QM;
    return W'(r);
  endfunction

  function automatic vec_t mk_model(input logic d, input logic [KW-1:0] k, input logic [L*W-1:0] a);
    vec_t v;
    v.d = d; v.k = k; v.a = a;
    for (int i = 0; i < L; i++) v.e[i*W +: W] = ref_lane(int'(a[i*W +: W]), d, int'(k));
    return v;
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: latency on first valid cycle, lane compare on each transfer.
  initial begin : monitor
    vec_t v;
    forever begin
      @(negedge clk);
      if (rst) begin
        first_seen = 1'b0;
      end else begin
        if (out_valid && !first_seen) begin
          first_seen = 1'b1;
          if (sb.size() == 0 || acc_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
          end else begin
            chk("latency_cycles", longint'(cyc - acc_q[0]), longint'(sb[0].k) + 1);
          end
        end
        if (out_valid && out_ready && sb.size() > 0 && acc_q.size() > 0) begin
          v = sb.pop_front();
          void'(acc_q.pop_front());
          for (int i = 0; i < L; i++) begin
            tests++;
            if (out_b[i*W +: W] !== v.e[i*W +: W]) begin
              fails++;
              $display("FAIL lane_result lane=%0d a=%0d k=%0d dir=%0d got=%0d expected=%0d",
                       i, v.a[i*W +: W], v.k, v.d, out_b[i*W +: W], v.e[i*W +: W]);
            end
          end
          first_seen = 1'b0;
        end
        if (in_valid && in_ready) acc_q.push_back(cyc);
      end
    end
  end

  // Drive one word and hold it until accepted; scrambles inputs afterwards.
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    sb.push_back(v);
    in_dir = v.d; in_k = v.k; in_a = v.a; in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_dir   = ~v.d;
    in_k     = KW'($urandom);
    in_a     = {$urandom, $urandom};
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 (t=%0t)", $time);
      void'(sb.pop_back());
    end
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    vec_t tbl[7];
    vec_t v;
    vec_t nv;
    bit   seen;

    tbl[0] = '{1'b0, 4'd1,  pack4(5, 4, 0, 3328),       pack4(1667, 2, 0, 1664)};
    tbl[1] = '{1'b0, 4'd1,  pack4(4000, 1, 2, 3329),    pack4(2000, 1665, 1, 0)};
    tbl[2] = '{1'b0, 4'd0,  pack4(3329, 4095, 7, 0),    pack4(0, 766, 7, 0)};
    tbl[3] = '{1'b0, 4'd3,  pack4(1, 1, 0, 8),          pack4(2913, 2913, 0, 1)};
    tbl[4] = '{1'b1, 4'd2,  pack4(2000, 1, 3328, 4000), pack4(1342, 4, 3325, 2684)};
    tbl[5] = '{1'b1, 4'd15, pack4(1, 0, 0, 0),          pack4(2807, 0, 0, 0)};
    tbl[6] = '{1'b1, 4'd1,  pack4(1665, 1664, 0, 3328), pack4(1, 3328, 0, 3327)};

    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_b", out_b, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i]);
      drain(100);
    end

    // Backpressure: result held 10 cycles, blocked input waits, then same-cycle handoff.
    man_ready = 1'b0;
    send(tbl[4]);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("bp_out_valid_seen", seen, 1);
    @(posedge clk);
    #1;
    nv = '{1'b0, 4'd1, pack4(7, 4000, 2, 3328), pack4(1668, 2000, 1, 1664)};
    sb.push_back(nv);
    in_dir = nv.d; in_k = nv.k; in_a = nv.a; in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_out_b_held", out_b, tbl[4].e);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_high", out_valid, 1);
      @(posedge clk);
      #1;
    end
    man_ready = 1'b1;
    @(negedge clk);
    chk("bp_handoff_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_stale_valid", out_valid, 0);
    @(posedge clk);
    #1;
    drain(100);

    // Reset five cycles into a k=15 run.
    v = mk_model(1'b0, 4'd15, pack4(1, 2, 3, 4));
    send(v);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("run_out_valid_low", out_valid, 0);
      @(posedge clk);
    end
    #1 rst = 1'b1;
    sb.delete();
    acc_q.delete();
    #1;
    chk("midrun_reset_out_valid", out_valid, 0);
    chk("midrun_reset_out_b", out_b, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_reset_in_ready", in_ready, 1);
    chk("midrun_reset_out_valid_after", out_valid, 0);
    @(posedge clk);
    #1;
    send('{1'b0, 4'd1, pack4(7, 7, 7, 7), pack4(1668, 1668, 1668, 1668)});
    drain(100);

    // Random regression against the reference model with random backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 3000 && fails < 50; t++) begin
      v = mk_model(1'($urandom_range(0, 1)), KW'($urandom_range(0, 15)),
                   pack4(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                         int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095))));
      send(v);
    end
    drain(400);
    rand_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
